// File: rtl/econ_input_packer.sv
// Packs N_IN W-bit trigger-cell samples from a valid/ready stream into one wide
// word for the econ encoder, with framing-error recovery and monitoring counters.
module econ_input_packer #(
    parameter int N_IN  = 48,
    parameter int W     = 8,
    parameter int ERR_W = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [W-1:0]        s_dat,
    input  logic                s_sof,
    input  logic                s_vld,
    output logic                s_rdy,
    output logic [N_IN*W-1:0]   input_1_rsc_dat,
    output logic                input_1_rsc_vld,
    output logic [15:0]         frame_cnt,
    output logic [ERR_W-1:0]    err_cnt,
    input  logic                err_clr
);

    localparam int CNT_W = $clog2(N_IN);
    localparam logic [CNT_W-1:0] LAST_SLOT = CNT_W'(N_IN - 1);

    typedef enum logic {
        IDLE,
        FILL
    } state_t;

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [N_IN*W-1:0]      fill_q, fill_d;
    logic [N_IN*W-1:0]      out_q, out_d;
    logic                   vld_q, vld_d;
    logic [15:0]            frame_q, frame_d;
    logic [ERR_W-1:0]       err_q, err_d;
    logic                   rdy_q;
    logic                   accept;
    logic                   err_inc;

    // s_rdy is a flop so it stays low through reset and rises on the first edge after release.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            fill_q  <= '0;
            out_q   <= '0;
            vld_q   <= 1'b0;
            frame_q <= '0;
            err_q   <= '0;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            fill_q  <= fill_d;
            out_q   <= out_d;
            vld_q   <= vld_d;
            frame_q <= frame_d;
            err_q   <= err_d;
            rdy_q   <= 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        fill_d  = fill_q;
        out_d   = out_q;
        vld_d   = 1'b0;
        frame_d = frame_q;
        err_inc = 1'b0;
        accept  = s_vld & rdy_q;

        if (accept) begin
            case (state_q)
                IDLE: begin
                    if (s_sof) begin
                        fill_d[W-1:0] = s_dat;
                        cnt_d         = CNT_W'(1);
                        state_d       = FILL;
                    end else begin
                        err_inc = 1'b1;
                    end
                end
                FILL: begin
                    // A premature sof abandons the partial frame and restarts at slot 0.
                    if (s_sof) begin
                        err_inc       = 1'b1;
                        fill_d[W-1:0] = s_dat;
                        cnt_d         = CNT_W'(1);
                    end else begin
                        fill_d[cnt_q*W +: W] = s_dat;
                        if (cnt_q == LAST_SLOT) begin
                            out_d   = fill_d;
                            vld_d   = 1'b1;
                            frame_d = frame_q + 16'd1;
                            cnt_d   = '0;
                            state_d = IDLE;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        err_d = err_q;
        if (err_clr) begin
            err_d = '0;
        end else if (err_inc && (err_q != {ERR_W{1'b1}})) begin
            err_d = err_q + ERR_W'(1);
        end
    end

    assign s_rdy           = rdy_q;
    assign input_1_rsc_dat = out_q;
    assign input_1_rsc_vld = vld_q;
    assign frame_cnt       = frame_q;
    assign err_cnt         = err_q;

endmodule

// File: tb/tb_econ_input_packer.sv
// Directed self-checking bench for econ_input_packer: frame packing, gaps,
// back-to-back frames, framing errors, async reset and counter saturation.
`timescale 1ns/1ps
module tb_econ_input_packer;

    localparam int N_IN = 48;
    localparam int W    = 8;
    localparam int OW   = N_IN * W;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic [W-1:0]    s_dat = '0;
    logic            s_sof = 1'b0;
    logic            s_vld = 1'b0;
    logic            s_rdy;
    logic [OW-1:0]   input_1_rsc_dat;
    logic            input_1_rsc_vld;
    logic [15:0]     frame_cnt;
    logic [7:0]      err_cnt;
    logic            err_clr = 1'b0;

    int total = 0;
    int bad   = 0;
    int holdBad = 0;
    logic [OW-1:0] gotQ[$];
    logic [OW-1:0] expQ[$];
    logic [OW-1:0] prevDat = '0;

    typedef struct {
        logic       vld;
        logic       sof;
        logic       clr;
        logic [7:0] dat;
        logic [7:0] expErr;
        logic       expVld;
    } vec_t;

    vec_t tbl[8];

    econ_input_packer #(.N_IN(N_IN), .W(W), .ERR_W(8)) dut (
        .clk             (clk),
        .rst             (rst),
        .s_dat           (s_dat),
        .s_sof           (s_sof),
        .s_vld           (s_vld),
        .s_rdy           (s_rdy),
        .input_1_rsc_dat (input_1_rsc_dat),
        .input_1_rsc_vld (input_1_rsc_vld),
        .frame_cnt       (frame_cnt),
        .err_cnt         (err_cnt),
        .err_clr         (err_clr)
    );

    always #5 clk = ~clk;

    // Captures every output pulse and flags any change of the output word between pulses.
    always @(negedge clk) begin
        if (!rst) begin
            prevDat = input_1_rsc_dat;
        end else begin
            if (input_1_rsc_vld) gotQ.push_back(input_1_rsc_dat);
            else if (input_1_rsc_dat !== prevDat) holdBad++;
            prevDat = input_1_rsc_dat;
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout want finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [OW-1:0] got, input logic [OW-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h want %0h", name, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic vld, input logic sof, input logic [7:0] dat, input logic clr);
        @(negedge clk);
        s_vld   = vld;
        s_sof   = sof;
        s_dat   = dat;
        err_clr = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic sendSample(input logic [7:0] dat, input logic sof, input bit gaps);
        if (gaps) begin
            while ($urandom_range(0, 99) < 30) applyStimulus(1'b0, 1'b1, 8'($urandom), 1'b0);
        end
        applyStimulus(1'b1, sof, dat, 1'b0);
    endtask

    task automatic sendFrame(input logic [7:0] base, input bit gaps);
        logic [OW-1:0] e;
        logic [7:0]    b;
        e = '0;
        for (int i = 0; i < N_IN; i++) begin
            b = base + 8'(i);
            e[i*W +: W] = b;
            sendSample(b, i == 0, gaps);
        end
        expQ.push_back(e);
    endtask

    task automatic idle(input int n);
        repeat (n) applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);
    endtask

    task automatic checkFrames(input string name);
        checkOutput({name, "_pulses"}, OW'(gotQ.size()), OW'(expQ.size()));
        for (int i = 0; i < expQ.size() && i < gotQ.size(); i++)
            checkOutput($sformatf("%s_data%0d", name, i), gotQ[i], expQ[i]);
        gotQ.delete();
        expQ.delete();
    endtask

    initial begin
        tbl[0] = '{vld:1'b0, sof:1'b0, clr:1'b1, dat:8'h00, expErr:8'd0, expVld:1'b0};
        tbl[1] = '{vld:1'b1, sof:1'b0, clr:1'b0, dat:8'h11, expErr:8'd1, expVld:1'b0};
        tbl[2] = '{vld:1'b0, sof:1'b0, clr:1'b0, dat:8'h22, expErr:8'd1, expVld:1'b0};
        tbl[3] = '{vld:1'b1, sof:1'b0, clr:1'b0, dat:8'h33, expErr:8'd2, expVld:1'b0};
        tbl[4] = '{vld:1'b1, sof:1'b0, clr:1'b0, dat:8'h44, expErr:8'd3, expVld:1'b0};
        tbl[5] = '{vld:1'b1, sof:1'b0, clr:1'b1, dat:8'h55, expErr:8'd0, expVld:1'b0};
        tbl[6] = '{vld:1'b0, sof:1'b1, clr:1'b0, dat:8'h66, expErr:8'd0, expVld:1'b0};
        tbl[7] = '{vld:1'b1, sof:1'b0, clr:1'b0, dat:8'h77, expErr:8'd1, expVld:1'b0};

        // Reset state, then release between edges.
        #1;
        checkOutput("rst_rdy", OW'(s_rdy), '0);
        checkOutput("rst_dat", input_1_rsc_dat, '0);
        checkOutput("rst_vld", OW'(input_1_rsc_vld), '0);
        checkOutput("rst_frame", OW'(frame_cnt), '0);
        checkOutput("rst_err", OW'(err_cnt), '0);
        #21 rst = 1'b1;
        #1 checkOutput("rdy_before_edge", OW'(s_rdy), '0);
        @(posedge clk); #1;
        checkOutput("rdy_after_edge", OW'(s_rdy), OW'(1));

        $display("[TB] basic frame");
        sendFrame(8'h01, 1'b0);
        checkOutput("basic_vld_latency", OW'(input_1_rsc_vld), OW'(1));
        checkOutput("basic_lsb", OW'(input_1_rsc_dat[7:0]), OW'(8'h01));
        checkOutput("basic_msb", OW'(input_1_rsc_dat[383:376]), OW'(8'h30));
        checkOutput("basic_frame_cnt", OW'(frame_cnt), OW'(1));
        idle(1);
        checkOutput("basic_vld_drop", OW'(input_1_rsc_vld), '0);
        idle(1);
        checkFrames("basic");
        checkOutput("basic_err", OW'(err_cnt), '0);

        $display("[TB] gaps and back-to-back");
        for (int f = 0; f < 3; f++) sendFrame(8'h50 + 8'(f * 8'h11), 1'b1);
        sendFrame(8'hC3, 1'b0);
        sendFrame(8'hE7, 1'b0);
        idle(2);
        checkFrames("b2b");
        checkOutput("b2b_frame_cnt", OW'(frame_cnt), OW'(6));
        checkOutput("b2b_hold", OW'(holdBad), '0);

        $display("[TB] premature sof");
        for (int i = 0; i < 19; i++) sendSample(8'hA0 + 8'(i), i == 0, 1'b0);
        sendFrame(8'h70, 1'b0);
        idle(2);
        checkFrames("premature");
        checkOutput("premature_err", OW'(err_cnt), OW'(1));
        checkOutput("premature_frame_cnt", OW'(frame_cnt), OW'(7));

        $display("[TB] orphan table");
        for (int i = 0; i < 8; i++) begin
            applyStimulus(tbl[i].vld, tbl[i].sof, tbl[i].dat, tbl[i].clr);
            checkOutput($sformatf("orphan_err%0d", i), OW'(err_cnt), OW'(tbl[i].expErr));
            checkOutput($sformatf("orphan_vld%0d", i), OW'(input_1_rsc_vld), OW'(tbl[i].expVld));
        end
        idle(1);
        checkFrames("orphan");
        checkOutput("orphan_frame_cnt", OW'(frame_cnt), OW'(7));

        $display("[TB] reset mid-frame");
        for (int i = 0; i < 30; i++) sendSample(8'h20 + 8'(i), i == 0, 1'b0);
        #2 rst = 1'b0;
        #1;
        checkOutput("midrst_rdy", OW'(s_rdy), '0);
        checkOutput("midrst_dat", input_1_rsc_dat, '0);
        checkOutput("midrst_vld", OW'(input_1_rsc_vld), '0);
        checkOutput("midrst_frame", OW'(frame_cnt), '0);
        checkOutput("midrst_err", OW'(err_cnt), '0);
        #3 rst = 1'b1;
        gotQ.delete();
        expQ.delete();
        sendFrame(8'h33, 1'b0);
        idle(2);
        checkFrames("postrst");
        checkOutput("postrst_frame_cnt", OW'(frame_cnt), OW'(1));
        checkOutput("postrst_err", OW'(err_cnt), '0);

        $display("[TB] err saturation");
        repeat (260) applyStimulus(1'b1, 1'b0, 8'h5A, 1'b0);
        checkOutput("sat_err", OW'(err_cnt), OW'(255));
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
        checkOutput("sat_clr", OW'(err_cnt), '0);
        checkOutput("sat_frame_cnt", OW'(frame_cnt), OW'(1));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
